// File: rtl/simple_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_pkg
// Description : Shared types and constants for the SIMPLE 16-bit pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_pkg;

    localparam int          INSTR_W    = 16;
    localparam logic [15:0] NOP_INSTR  = 16'hC0E0;
    localparam logic [15:0] HALT_INSTR = 16'hC0F0;

    // Fetch controller: BOOT primes the ROM read, RUN streams instructions
    typedef enum logic [0:0] {
        FS_BOOT = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_t;

endpackage : simple_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register (instruction, PC+1, valid) with
//               load, hold and bubble controls. Bubble wins over load.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import simple_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [INSTR_W-1:0] pc_plus1_d,
    output logic [INSTR_W-1:0] instruction,
    output logic [INSTR_W-1:0] pc_plus1,
    output logic               valid
);

    logic [INSTR_W-1:0] r_instruction;
    logic [INSTR_W-1:0] r_pc_plus1;
    logic               r_valid;

    // Bubble inserts a NOP, load captures a fetched instruction, else hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instruction <= NOP_INSTR;
            r_pc_plus1    <= '0;
            r_valid       <= 1'b0;
        end else if (bubble) begin
            r_instruction <= NOP_INSTR;
            r_pc_plus1    <= '0;
            r_valid       <= 1'b0;
        end else if (load) begin
            r_instruction <= instr_d;
            r_pc_plus1    <= pc_plus1_d;
            r_valid       <= 1'b1;
        end
    end

    assign instruction = r_instruction;
    assign pc_plus1    = r_pc_plus1;
    assign valid       = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, addresses the
//               synchronous instruction ROM and feeds the IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import simple_pkg::*;
#(
    parameter int IMEM_AW = 12
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               run,
    input  logic               pc_write,
    input  logic               if_flush,
    input  logic               stall,
    input  logic               branch,
    input  logic [INSTR_W-1:0] branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_q,
    output logic [INSTR_W-1:0] if_id_instruction,
    output logic [INSTR_W-1:0] if_id_pc_plus1,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] fetch_count
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [INSTR_W-1:0] r_pc;
    logic [INSTR_W-1:0] w_pc_next;
    logic [INSTR_W-1:0] w_pc_plus1;
    logic [INSTR_W-1:0] r_fetch_count;
    logic               w_load;
    logic               w_bubble;
    logic               w_count_en;

    // 16-bit modulo increment; 0xFFFF rolls to 0x0000
    assign w_pc_plus1 = r_pc + INSTR_W'(1);

    // State, PC and fetch counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= FS_BOOT;
            r_pc          <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_count_en) begin
                r_fetch_count <= r_fetch_count + INSTR_W'(1);
            end
        end
    end

    // Next-state, PC mux and IF/ID controls; every hold case re-reads pc
    // so that imem_q keeps matching pc for the next running clock
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_count_en   = 1'b0;
        case (r_state)
            FS_BOOT: begin
                // ROM output is not valid yet: prime address 0, emit a bubble
                if (run) begin
                    w_state_next = FS_RUN;
                    w_pc_next    = '0;
                    w_bubble     = 1'b1;
                end
            end
            FS_RUN: begin
                if (!run) begin
                    w_pc_next = r_pc;
                end else if (branch) begin
                    w_pc_next = branch_target;
                    w_bubble  = 1'b1;
                end else if (if_flush) begin
                    w_bubble  = 1'b1;
                    w_pc_next = pc_write ? w_pc_plus1 : r_pc;
                end else if (stall) begin
                    w_pc_next = r_pc;
                end else if (!pc_write) begin
                    w_bubble  = 1'b1;
                end else begin
                    w_load     = 1'b1;
                    w_count_en = 1'b1;
                    w_pc_next  = w_pc_plus1;
                end
            end
            default: begin
                w_state_next = FS_BOOT;
            end
        endcase
    end

    if_id_reg u_if_id_reg (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (w_load),
        .bubble      (w_bubble),
        .instr_d     (imem_q),
        .pc_plus1_d  (w_pc_plus1),
        .instruction (if_id_instruction),
        .pc_plus1    (if_id_pc_plus1),
        .valid       (if_id_valid)
    );

    // The ROM aliases: only the low address bits reach it
    assign imem_addr   = w_pc_next[IMEM_AW-1:0];
    assign pc          = r_pc;
    assign fetch_count = r_fetch_count;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a ROM model and a
//               rule-level reference model of the fetch stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import simple_pkg::*;

    localparam int AW = 12;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          run = 1'b1, pc_write = 1'b1, if_flush = 1'b0;
    logic          stall = 1'b0, branch = 1'b0;
    logic [15:0]   branch_target = 16'h0;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_q = 16'h0;
    logic [15:0]   if_id_instruction, if_id_pc_plus1, pc, fetch_count;
    logic          if_id_valid;

    logic [15:0]   rom [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    fetch_stage #(.IMEM_AW(AW)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .run               (run),
        .pc_write          (pc_write),
        .if_flush          (if_flush),
        .stall             (stall),
        .branch            (branch),
        .branch_target     (branch_target),
        .imem_addr         (imem_addr),
        .imem_q            (imem_q),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus1    (if_id_pc_plus1),
        .if_id_valid       (if_id_valid),
        .pc                (pc),
        .fetch_count       (fetch_count)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data is mem[address registered on the previous edge]
    always @(posedge clock) imem_q <= rom[imem_addr];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The fetch stream as a sequence of PC values: each running clock moves
    // the PC by the highest-priority rule; a normal clock delivers rom[pc].
    logic        m_booted = 1'b0;
    logic [15:0] m_pc = 16'h0, m_instr = NOP_INSTR, m_pc1 = 16'h0, m_count = 16'h0;
    logic        m_valid = 1'b0;

    function automatic logic [15:0] exp_pc_next();
        if (!m_booted || !run)   return m_booted ? m_pc : 16'h0;
        if (branch)              return branch_target;
        if (if_flush)            return pc_write ? m_pc + 16'd1 : m_pc;
        if (stall || !pc_write)  return m_pc;
        return m_pc + 16'd1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_booted <= 1'b0; m_pc <= 16'h0; m_instr <= NOP_INSTR;
            m_pc1 <= 16'h0; m_valid <= 1'b0; m_count <= 16'h0;
        end else if (!m_booted) begin
            if (run) begin
                m_booted <= 1'b1; m_instr <= NOP_INSTR; m_valid <= 1'b0;
            end
        end else if (run) begin
            m_pc <= exp_pc_next();
            if (branch || if_flush || (!stall && !pc_write)) begin
                m_instr <= NOP_INSTR; m_valid <= 1'b0;
            end else if (!stall) begin
                m_instr <= rom[m_pc[AW-1:0]];
                m_pc1   <= m_pc + 16'd1;
                m_valid <= 1'b1;
                m_count <= m_count + 16'd1;
            end
        end
    end

    // Compare every cycle, mid-period, with inputs already settled
    always @(negedge clock) begin
        chk("pc", pc, m_pc);
        chk("instr", if_id_instruction, m_instr);
        chk("valid", {15'h0, if_id_valid}, {15'h0, m_valid});
        if (m_valid) chk("pc_plus1", if_id_pc_plus1, m_pc1);
        chk("fetch_count", fetch_count, m_count);
        chk("imem_addr", {4'h0, imem_addr}, {4'h0, exp_pc_next() & 16'h0FFF});
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic drive(input logic r, input logic pw, input logic fl,
                         input logic st, input logic br, input logic [15:0] tg);
        run = r; pc_write = pw; if_flush = fl; stall = st; branch = br; branch_target = tg;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 16'(i) ^ 16'h5A00;
        rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
        rom[12'h040] = 16'h4040;
        rom[12'hFFF] = HALT_INSTR;

        #1 reset_n = 1'b0;
        #1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", if_id_instruction, 16'hC0E0);
        chk("rst_pc1", if_id_pc_plus1, 16'h0000);
        chk("rst_valid", {15'h0, if_id_valid}, 16'h0);
        chk("rst_count", fetch_count, 16'h0);
        chk("rst_addr", {4'h0, imem_addr}, 16'h0);
        cyc(2);
        drive(1, 1, 0, 0, 0, 16'h0);
        reset_n = 1'b1;

        // Boot: bubble, then mem[0], mem[1], mem[2]
        cyc(1);
        chk("boot_valid", {15'h0, if_id_valid}, 16'h0);
        cyc(1);
        chk("boot_i0", if_id_instruction, 16'h1111);
        chk("boot_p0", if_id_pc_plus1, 16'h0001);
        cyc(1);
        chk("boot_i1", if_id_instruction, 16'h2222);
        cyc(1);
        chk("boot_i2", if_id_instruction, 16'h3333);
        chk("boot_cnt", fetch_count, 16'd3);

        // Stall three clocks holding mem[2], then mem[3]
        drive(1, 1, 0, 1, 0, 16'h0);
        cyc(3);
        chk("stall_i", if_id_instruction, 16'h3333);
        chk("stall_pc", pc, 16'h0003);
        chk("stall_cnt", fetch_count, 16'd3);
        drive(1, 1, 0, 0, 0, 16'h0);
        cyc(1);
        chk("post_stall_i", if_id_instruction, 16'h4444);
        chk("post_stall_cnt", fetch_count, 16'd4);

        // Branch from pc=5 to 0x40
        cyc(1);
        chk("pre_br_pc", pc, 16'h0005);
        drive(1, 1, 0, 0, 1, 16'h0040);
        cyc(1);
        chk("br_bubble", if_id_instruction, 16'hC0E0);
        chk("br_pc", pc, 16'h0040);
        drive(1, 1, 0, 0, 0, 16'h0);
        cyc(1);
        chk("br_tgt_i", if_id_instruction, 16'h4040);
        chk("br_tgt_p1", if_id_pc_plus1, 16'h0041);

        // Branch together with stall: same result
        drive(1, 1, 0, 1, 1, 16'h0040);
        cyc(1);
        chk("brst_bubble", {15'h0, if_id_valid}, 16'h0);
        drive(1, 1, 0, 0, 0, 16'h0);
        cyc(1);
        chk("brst_tgt_i", if_id_instruction, 16'h4040);
        chk("brst_tgt_p1", if_id_pc_plus1, 16'h0041);

        // Halt drain: flush with pc_write=0 for four clocks
        drive(1, 0, 1, 0, 0, 16'h0);
        cyc(4);
        chk("drain_pc", pc, 16'h0041);
        chk("drain_i", if_id_instruction, 16'hC0E0);
        // Flush with pc_write=1 advances the PC; pc_write=0 alone bubbles
        drive(1, 1, 1, 0, 0, 16'h0);
        cyc(1);
        chk("flush_pc", pc, 16'h0042);
        drive(1, 0, 0, 0, 0, 16'h0);
        cyc(1);
        chk("pcw0_pc", pc, 16'h0042);

        // Wrap at 0xFFFF
        drive(1, 1, 0, 0, 1, 16'hFFFF);
        cyc(1);
        drive(1, 1, 0, 0, 0, 16'h0);
        #1;
        chk("wrap_addr", {4'h0, imem_addr}, 16'h0000);
        cyc(1);
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_p1", if_id_pc_plus1, 16'h0000);
        chk("wrap_i", if_id_instruction, HALT_INSTR);

        // Freeze for five clocks, then resume without a bubble
        cyc(2);
        drive(0, 1, 0, 0, 0, 16'h0);
        cyc(5);
        chk("frz_i", if_id_instruction, 16'h2222);
        chk("frz_pc", pc, 16'h0002);
        chk("frz_addr", {4'h0, imem_addr}, 16'h0002);
        drive(1, 1, 0, 0, 0, 16'h0);
        cyc(1);
        chk("resume_i", if_id_instruction, 16'h3333);
        chk("resume_valid", {15'h0, if_id_valid}, 16'h1);

        // Asynchronous reset between edges
        reset_n = 1'b0;
        #1;
        chk("arst_pc", pc, 16'h0000);
        chk("arst_instr", if_id_instruction, 16'hC0E0);
        chk("arst_valid", {15'h0, if_id_valid}, 16'h0);
        chk("arst_count", fetch_count, 16'h0);
        chk("arst_addr", {4'h0, imem_addr}, 16'h0);
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        chk("reboot_i0", if_id_instruction, 16'h1111);

        cyc(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the SIMPLE 16-bit pipeline: owns the program counter, drives the synchronous instruction memory and loads the IF/ID pipeline register that the decode/control stage reads. It consumes the controller's run, flush and PC-write signals, the hazard unit's stall and the branch decision with its target. It delivers one instruction per running cycle, or a NOP bubble.

## Interface
- IMEM_AW, 12: instruction memory address width; `imem_addr` is `pc_next[IMEM_AW-1:0]`.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  controller's systemRunning; 0 freezes all state
- pc_write  in  1  controller PCWrite; 0 blocks the sequential PC increment
- if_flush  in  1  controller IFFlush; loads a NOP bubble into IF/ID
- stall  in  1  load-use stall from hazard unit; holds PC and IF/ID
- branch  in  1  taken-branch decision (p4)
- branch_target  in  16  PC to load when `branch`=1
- imem_addr  out  IMEM_AW  synchronous-ROM read address; combinational from `pc_next`
- imem_q  in  16  ROM data; equals mem[addr registered on previous edge]
- if_id_instruction  out  16  instruction for decode/control
- if_id_pc_plus1  out  16  PC+1 of that instruction, for branch-target arithmetic
- if_id_valid  out  1  1 = real fetched instruction, 0 = bubble
- pc  out  16  current PC; imem_q corresponds to it in RUN
- fetch_count  out  16  count of valid instructions loaded into IF/ID; wraps

## Operation
- FSM states are BOOT and RUN.
  - Reset enters BOOT.
  - BOOT → RUN on the first clock with `run`=1.
  - RUN never returns to BOOT except through reset.
- BOOT, `run`=1 clock:
  - `pc_next`=0.
  - IF/ID ← NOP and valid=0, because the ROM output is not yet valid.
  - `pc` stays 0.
- RUN: `pc_next` and the IF/ID update follow this priority order, highest first:
  1. `run`=0: everything holds; `pc_next`=`pc`, so the ROM keeps re-reading the current PC.
  2. `branch`=1: `pc_next`=`branch_target`; `pc`←target; IF/ID ← NOP, valid=0. This overrides `stall`, `if_flush` and `pc_write`.
  3. `if_flush`=1: IF/ID ← NOP, valid=0. `pc_next`=`pc`+1 if `pc_write`=1, else `pc`.
  4. `stall`=1: `pc_next`=`pc`; `pc` and IF/ID hold.
  5. `pc_write`=0: `pc_next`=`pc`; IF/ID ← NOP, valid=0.
  6. Normal: IF/ID ← {`imem_q`, `pc`+1}, valid=1; `pc_next`=`pc`+1; `pc`←`pc`+1.
- `fetch_count` increments only on case 6.
- PC arithmetic is 16-bit modulo: 0xFFFF+1 = 0x0000. `imem_addr` takes the low IMEM_AW bits, so the ROM aliases.
- NOP encoding is 16'hC0E0 ([15:14]=11, [7:4]=1110).
- Flushing of ID/EX and EX/MEM on a branch is not this block's job.

## Timing
- Reset values:
  - `pc`=0x0000, `pc_next`/`imem_addr`=0.
  - `if_id_instruction`=0xC0E0, `if_id_pc_plus1`=0x0000, `if_id_valid`=0.
  - `fetch_count`=0, state=BOOT.
- Fetch latency: the ROM address is presented in cycle N, and the instruction appears in IF/ID after the edge ending cycle N+1.
- First instruction: mem[0] is in IF/ID two running clocks after reset release (BOOT clock, then the first RUN clock).
- Branch penalty at the IF/ID boundary:
  - The branch clock inserts one bubble.
  - The next clock loads mem[target].
- Stall: IF/ID is held for the stall cycles; the next non-stall clock loads the same instruction that was at `pc`, with no duplication or loss.
- `run` falling mid-operation: state freezes exactly. Resuming continues with no bubble, because `imem_q` is still mem[`pc`].
- If `reset_n` asserts mid-operation, all outputs go to their reset values immediately (asynchronously).

## Structure
- Shared package `simple_pkg` holds:
  - `NOP_INSTR`=16'hC0E0 and `HALT_INSTR`=16'hC0F0;
  - the enum `fetch_state_t {FS_BOOT, FS_RUN}`;
  - `INSTR_W`=16.
- Sub-module `if_id_reg` holds the instruction, PC+1 and valid, with load/hold/bubble controls. The PC mux and FSM stay in `fetch_stage`.

## Test plan
- **Boot:** ROM mem[0..3]=0x1111,0x2222,0x3333,0x4444; release reset with `run`=1 → IF/ID shows 0x1111/pc_plus1 1 on the 2nd clock, then 0x2222, 0x3333, valid=1; `fetch_count`=3.
- **Branch:** `branch`=1, target=0x0040 while `pc`=0x0005 → next IF/ID is 0xC0E0 with valid=0, the one after is mem[0x40] with pc_plus1 0x0041. Repeat with `stall`=1 asserted together with `branch` → identical result.
- **Stall:** `stall` held for 3 clocks with IF/ID=mem[2] → IF/ID stays mem[2] and `pc` is unchanged; the following clock loads mem[3]; `fetch_count` advances by 1 only.
- **Halt drain:** `pc_write`=0 and `if_flush`=1 for 4 clocks → bubbles with valid=0, `pc` constant, `fetch_count` constant.
- **Wrap:** `pc` forced via branch to 0xFFFF → next `pc`=0x0000 and `if_id_pc_plus1`=0x0000; `imem_addr`=0.
- **Freeze/reset:** `run`=0 for 5 clocks mid-stream → no change, then resumes with no bubble. Assert `reset_n`=0 between clock edges → outputs reach reset values before the next edge.
